// File: rtl/perf_ctr_pkg.sv
// Shared constants for the performance counter bank: counting modes, word offsets, CTRL/GCTRL bit positions.
// Optional irq output and CTRL irq_en bit are enabled by defining PERF_CTR_IRQ_EN.
package perf_ctr_pkg;

    localparam logic [1:0] MODE_CYC = 2'b00;
    localparam logic [1:0] MODE_EVT = 2'b01;
    localparam logic [1:0] MODE_RET = 2'b10;
    localparam logic [1:0] MODE_STL = 2'b11;

    // Offsets inside a counter's 4-word block, and inside the global block at 4*NUM_CTRS
    localparam logic [1:0] OFS_LO   = 2'd0;
    localparam logic [1:0] OFS_HI   = 2'd1;
    localparam logic [1:0] OFS_CTRL = 2'd2;
    localparam int OFS_GCTRL = 0;
    localparam int OFS_OVF   = 1;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IRQ_EN   = 4;
    localparam int GCTRL_FREEZE  = 0;
    localparam int GCTRL_CLR_ALL = 1;

    function automatic logic mode_hit(input logic [1:0] mode, input logic evt, input logic stall);
        logic hit;
        case (mode)
            MODE_CYC: hit = 1'b1;
            MODE_EVT: hit = evt;
            MODE_RET: hit = evt & ~stall;
            default:  hit = stall;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/perf_ctr_slice.sv
// One performance counter: count register, CTRL fields, HI snapshot shadow and sticky overflow flag.
// The irq_en CTRL bit only exists when PERF_CTR_IRQ_EN is defined.
module perf_ctr_slice
    import perf_ctr_pkg::*;
#(
    parameter int CTR_WIDTH = 48
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  event_inc,
    input  logic                  freeze,
    input  logic                  clr_all,
    input  logic                  wr_lo,
    input  logic                  wr_hi,
    input  logic                  wr_ctrl,
    input  logic                  rd_lo,
    input  logic                  ovf_clr,
    input  logic [31:0]           wdata,
    output logic [31:0]           cnt_lo,
    output logic [CTR_WIDTH-33:0] shadow,
    output logic [31:0]           ctrl_word,
`ifdef PERF_CTR_IRQ_EN
    output logic                  irq_en,
`endif
    output logic                  ovf
);

    localparam int HW = CTR_WIDTH - 32;
    localparam logic [CTR_WIDTH-1:0] ONE = CTR_WIDTH'(1);

    logic [CTR_WIDTH-1:0] cnt_reg;
    logic [HW-1:0]        shadow_reg;
    logic                 en_reg;
    logic [1:0]           mode_reg;
    logic                 irq_en_reg;
    logic                 ovf_reg;
    logic                 inc;
    logic                 wrap;

    assign inc  = en_reg & ~freeze & mode_hit(mode_reg, event_inc, stall);
    // An increment pre-empted by clr_all or a bus write is lost, so it cannot wrap either
    assign wrap = inc & ~clr_all & ~wr_lo & ~wr_hi & (&cnt_reg);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= '0;
            shadow_reg <= '0;
            en_reg     <= 1'b0;
            mode_reg   <= MODE_CYC;
            ovf_reg    <= 1'b0;
        end else begin
            if (clr_all)
                cnt_reg <= '0;
            else if (wr_lo)
                cnt_reg[31:0] <= wdata;
            else if (wr_hi)
                cnt_reg[CTR_WIDTH-1:32] <= wdata[HW-1:0];
            else if (inc)
                cnt_reg <= cnt_reg + ONE;

            if (wr_hi)
                shadow_reg <= wdata[HW-1:0];
            else if (rd_lo)
                shadow_reg <= cnt_reg[CTR_WIDTH-1:32];

            if (wr_ctrl) begin
                en_reg   <= wdata[CTRL_EN];
                mode_reg <= wdata[CTRL_MODE_LSB +: 2];
            end

            if (wrap)
                ovf_reg <= 1'b1;
            else if (ovf_clr)
                ovf_reg <= 1'b0;
        end
    end

`ifdef PERF_CTR_IRQ_EN
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            irq_en_reg <= 1'b0;
        else if (wr_ctrl)
            irq_en_reg <= wdata[CTRL_IRQ_EN];
    end
    assign irq_en = irq_en_reg;
`else
    assign irq_en_reg = 1'b0;
`endif

    assign cnt_lo    = cnt_reg[31:0];
    assign shadow    = shadow_reg;
    assign ctrl_word = {27'd0, irq_en_reg, 1'b0, mode_reg, en_reg} & 32'h0000_0017;
    assign ovf       = ovf_reg;

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of NUM_CTRS performance counters with tear-free LO/HI reads and a 2-stage read path.
// Define PERF_CTR_IRQ_EN to add the registered irq output and the per-counter irq_en CTRL bit.
module perf_counter_bank
    import perf_ctr_pkg::*;
#(
    parameter int NUM_CTRS  = 4,
    parameter int CTR_WIDTH = 48,
    parameter int ADDR_W    = 6
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                stall,
    input  logic [NUM_CTRS-1:0] event_inc,
    input  logic                ct_req,
    input  logic                ct_we,
    input  logic [ADDR_W-1:0]   ct_addr,
    input  logic [31:0]         ct_wdata,
    output logic [31:0]         ct_rdata,
    output logic                ct_rvalid,
`ifdef PERF_CTR_IRQ_EN
    output logic                irq,
`endif
    output logic [NUM_CTRS-1:0] ovf_status
);

    localparam logic [ADDR_W-1:0] GCTRL_ADDR = ADDR_W'(4 * NUM_CTRS + OFS_GCTRL);
    localparam logic [ADDR_W-1:0] OVF_ADDR   = ADDR_W'(4 * NUM_CTRS + OFS_OVF);

    logic                   wr;
    logic                   rd;
    logic                   gctrl_wr;
    logic                   clr_all;
    logic                   freeze_reg;
    logic [31:0]            cnt_lo    [NUM_CTRS];
    logic [CTR_WIDTH-33:0]  shadow    [NUM_CTRS];
    logic [31:0]            ctrl_word [NUM_CTRS];
    logic [31:0]            rd_word;
    logic                   rvalid_pipe_reg;
    logic [31:0]            rdata_pipe_reg;
`ifdef PERF_CTR_IRQ_EN
    logic [NUM_CTRS-1:0]    irq_en_vec;
`endif

    assign wr       = ct_req & ct_we;
    assign rd       = ct_req & ~ct_we;
    assign gctrl_wr = wr & (ct_addr == GCTRL_ADDR);
    assign clr_all  = gctrl_wr & ct_wdata[GCTRL_CLR_ALL];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTRS; gi++) begin : g_ctr
            logic hit;
            assign hit = (ct_addr[ADDR_W-1:2] == (ADDR_W-2)'(gi));

            perf_ctr_slice #(
                .CTR_WIDTH (CTR_WIDTH)
            ) u_slice (
                .CLK       (CLK),
                .reset     (reset),
                .stall     (stall),
                .event_inc (event_inc[gi]),
                .freeze    (freeze_reg),
                .clr_all   (clr_all),
                .wr_lo     (wr & hit & (ct_addr[1:0] == OFS_LO)),
                .wr_hi     (wr & hit & (ct_addr[1:0] == OFS_HI)),
                .wr_ctrl   (wr & hit & (ct_addr[1:0] == OFS_CTRL)),
                .rd_lo     (rd & hit & (ct_addr[1:0] == OFS_LO)),
                .ovf_clr   (wr & (ct_addr == OVF_ADDR) & ct_wdata[gi]),
                .wdata     (ct_wdata),
                .cnt_lo    (cnt_lo[gi]),
                .shadow    (shadow[gi]),
                .ctrl_word (ctrl_word[gi]),
`ifdef PERF_CTR_IRQ_EN
                .irq_en    (irq_en_vec[gi]),
`endif
                .ovf       (ovf_status[gi])
            );
        end
    endgenerate

    // Read data is captured on the request edge together with the HI snapshot, so LO/HI stay consistent
    always_comb begin
        rd_word = 32'd0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (ct_addr[ADDR_W-1:2] == (ADDR_W-2)'(i)) begin
                case (ct_addr[1:0])
                    OFS_LO:   rd_word = cnt_lo[i];
                    OFS_HI:   rd_word = 32'(shadow[i]);
                    OFS_CTRL: rd_word = ctrl_word[i];
                    default:  rd_word = 32'd0;
                endcase
            end
        end
        if (ct_addr == GCTRL_ADDR)
            rd_word = {31'd0, freeze_reg};
        else if (ct_addr == OVF_ADDR)
            rd_word = 32'(ovf_status);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            freeze_reg      <= 1'b0;
            rvalid_pipe_reg <= 1'b0;
            rdata_pipe_reg  <= 32'd0;
            ct_rvalid       <= 1'b0;
            ct_rdata        <= 32'd0;
        end else begin
            if (gctrl_wr)
                freeze_reg <= ct_wdata[GCTRL_FREEZE];
            rvalid_pipe_reg <= rd;
            if (rd)
                rdata_pipe_reg <= rd_word;
            ct_rvalid <= rvalid_pipe_reg;
            if (rvalid_pipe_reg)
                ct_rdata <= rdata_pipe_reg;
        end
    end

`ifdef PERF_CTR_IRQ_EN
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            irq <= 1'b0;
        else
            irq <= |(ovf_status & irq_en_vec);
    end
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed, table-driven bench for perf_counter_bank (4 x 48-bit counters); also builds with PERF_CTR_IRQ_EN.
module tb_perf_counter_bank;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [N-1:0] event_inc;
    logic        ct_req;
    logic        ct_we;
    logic [5:0]  ct_addr;
    logic [31:0] ct_wdata;
    logic [31:0] ct_rdata;
    logic        ct_rvalid;
    logic [N-1:0] ovf_status;
`ifdef PERF_CTR_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_RB = 32'h0000_0016;
`else
    localparam logic [31:0] CTRL_RB = 32'h0000_0006;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    perf_counter_bank #(.NUM_CTRS(N), .CTR_WIDTH(48), .ADDR_W(6)) dut (
        .CLK        (clk),
        .reset      (rst_n),
        .stall      (stall),
        .event_inc  (event_inc),
        .ct_req     (ct_req),
        .ct_we      (ct_we),
        .ct_addr    (ct_addr),
        .ct_wdata   (ct_wdata),
        .ct_rdata   (ct_rdata),
        .ct_rvalid  (ct_rvalid),
`ifdef PERF_CTR_IRQ_EN
        .irq        (irq),
`endif
        .ovf_status (ovf_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge; the write lands on the following posedge, returns at the next negedge
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        ct_req = 1'b1; ct_we = 1'b1; ct_addr = a; ct_wdata = d;
        @(negedge clk);
        ct_req = 1'b0; ct_we = 1'b0;
        $display("wr addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        ct_req = 1'b1; ct_we = 1'b0; ct_addr = a;
        @(negedge clk);
        ct_req = 1'b0;
        @(negedge clk);
        check("rvalid", {63'd0, ct_rvalid}, 64'd1);
        d = ct_rdata;
        $display("rd addr=%0d data=0x%08h", a, d);
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, {32'd0, d}, {32'd0, exp});
    endtask

    logic [7:0] pat_e;
    logic [7:0] pat_s;

    initial begin
        tbl[0]  = '{1'b1, 6'd6,  32'hFFFF_FFFE, 32'h0};
        tbl[1]  = '{1'b0, 6'd6,  32'h0,         CTRL_RB};
        tbl[2]  = '{1'b1, 6'd4,  32'hDEAD_BEEF, 32'h0};
        tbl[3]  = '{1'b1, 6'd5,  32'hFFFF_FFFF, 32'h0};
        tbl[4]  = '{1'b0, 6'd5,  32'h0,         32'h0000_FFFF};
        tbl[5]  = '{1'b0, 6'd4,  32'h0,         32'hDEAD_BEEF};
        tbl[6]  = '{1'b1, 6'd3,  32'hFFFF_FFFF, 32'h0};
        tbl[7]  = '{1'b0, 6'd3,  32'h0,         32'h0};
        tbl[8]  = '{1'b1, 6'd18, 32'hFFFF_FFFF, 32'h0};
        tbl[9]  = '{1'b0, 6'd18, 32'h0,         32'h0};
        tbl[10] = '{1'b1, 6'd16, 32'h1,         32'h0};
        tbl[11] = '{1'b0, 6'd16, 32'h0,         32'h1};
        tbl[12] = '{1'b1, 6'd16, 32'h2,         32'h0};
        tbl[13] = '{1'b0, 6'd16, 32'h0,         32'h0};
        tbl[14] = '{1'b0, 6'd4,  32'h0,         32'h0};
        tbl[15] = '{1'b0, 6'd5,  32'h0,         32'h0};
        tbl[16] = '{1'b0, 6'd17, 32'h0,         32'h0};
        tbl[17] = '{1'b1, 6'd6,  32'h0,         32'h0};
        tbl[18] = '{1'b0, 6'd6,  32'h0,         32'h0};
        tbl[19] = '{1'b0, 6'd63, 32'h0,         32'h0};
        pat_e = 8'b0110_1011;   // cycle 0 is bit 0
        pat_s = 8'b1010_0110;

        rst_n = 1'b0; stall = 1'b0; event_inc = '0;
        ct_req = 1'b0; ct_we = 1'b0; ct_addr = '0; ct_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_rvalid", {63'd0, ct_rvalid}, 64'd0);
        check("reset_rdata", {32'd0, ct_rdata}, 64'd0);
        check("reset_ovf", {60'd0, ovf_status}, 64'd0);
`ifdef PERF_CTR_IRQ_EN
        check("reset_irq", {63'd0, irq}, 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 1: every mapped word reads 0 after reset
        for (int a = 0; a < 4 * N + 2; a++)
            read_check($sformatf("reset_word%0d", a), 6'(a), 32'h0);

        // Register behaviour with all counters disabled
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].we)
                bus_write(tbl[i].addr, tbl[i].wdata);
            else
                read_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
        end

        // Back-to-back reads: one rvalid pulse per request
        bus_write(6'd4, 32'hA5A5_0001);
        bus_write(6'd8, 32'h5A5A_0002);
        ct_req = 1'b1; ct_we = 1'b0; ct_addr = 6'd4;
        @(negedge clk); ct_addr = 6'd8;
        @(negedge clk); ct_req = 1'b0;
        check("b2b_rvalid0", {63'd0, ct_rvalid}, 64'd1);
        check("b2b_rdata0", {32'd0, ct_rdata}, 64'hA5A5_0001);
        @(negedge clk);
        check("b2b_rvalid1", {63'd0, ct_rvalid}, 64'd1);
        check("b2b_rdata1", {32'd0, ct_rdata}, 64'h5A5A_0002);
        @(negedge clk);
        check("b2b_rvalid_end", {63'd0, ct_rvalid}, 64'd0);

        // Modes: 00/01/10/11 on counters 0..3 over an 8-cycle event/stall pattern
        bus_write(6'd16, 32'h1);
        bus_write(6'd2,  32'h1);
        bus_write(6'd6,  32'h3);
        bus_write(6'd10, 32'h5);
        bus_write(6'd14, 32'h7);
        bus_write(6'd16, 32'h3);
        bus_write(6'd16, 32'h0);
        for (int j = 0; j < 8; j++) begin
            event_inc = {N{pat_e[j]}};
            stall = pat_s[j];
            @(negedge clk);
        end
        event_inc = '0; stall = 1'b0;
        bus_write(6'd16, 32'h1);
        read_check("mode_cyc", 6'd0, 32'd9);
        read_check("mode_evt", 6'd4, 32'd5);
        read_check("mode_ret", 6'd8, 32'd3);
        read_check("mode_stl", 6'd12, 32'd4);

        // Freeze holds every counter even with all conditions active
        event_inc = '1; stall = 1'b1;
        repeat (20) @(negedge clk);
        read_check("freeze_c0", 6'd0, 32'd9);
        read_check("freeze_c1", 6'd4, 32'd5);
        read_check("freeze_c2", 6'd8, 32'd3);
        read_check("freeze_c3", 6'd12, 32'd4);
        event_inc = '0; stall = 1'b0;

        // 2: cycle mode ignores stall
        bus_write(6'd6,  32'h0);
        bus_write(6'd10, 32'h0);
        bus_write(6'd14, 32'h0);
        bus_write(6'd16, 32'h2);
        for (int j = 0; j < 10; j++) begin
            stall = ~stall;
            @(negedge clk);
        end
        stall = 1'b0;
        read_check("cycles10", 6'd0, 32'd10);

        stall = 1'b1; event_inc = '1;
        bus_write(6'd2, 32'h5);
        bus_write(6'd0, 32'h0000_1234);
        repeat (5) @(negedge clk);
        read_check("ret_stalled_lo", 6'd0, 32'h0000_1234);
        read_check("ret_stalled_hi", 6'd1, 32'h0);
        stall = 1'b0; event_inc = '0;

        // 3: wrap sets the sticky flag, W1C clears it
        bus_write(6'd2, 32'h0);
        bus_write(6'd1, 32'h0000_FFFF);
        bus_write(6'd0, 32'hFFFF_FFFE);
        bus_write(6'd2, 32'h11);
        check("ovf_before0", {60'd0, ovf_status}, 64'd0);
        @(negedge clk);
        check("ovf_before1", {60'd0, ovf_status}, 64'd0);
        @(negedge clk);
        check("ovf_set", {60'd0, ovf_status}, 64'd1);
`ifdef PERF_CTR_IRQ_EN
        check("irq_lag", {63'd0, irq}, 64'd0);
`endif
        @(negedge clk);
`ifdef PERF_CTR_IRQ_EN
        check("irq_set", {63'd0, irq}, 64'd1);
`endif
        read_check("ovf_read", 6'd17, 32'h1);
        bus_write(6'd17, 32'h1);
        check("ovf_clr", {60'd0, ovf_status}, 64'd0);
        @(negedge clk);
`ifdef PERF_CTR_IRQ_EN
        check("irq_clr", {63'd0, irq}, 64'd0);
`endif

        // 4: HI returns the snapshot taken by the preceding LO read
        bus_write(6'd1, 32'h1);
        bus_write(6'd0, 32'hFFFF_FFFD);
        repeat (2) @(negedge clk);
        read_check("snap_lo", 6'd0, 32'hFFFF_FFFF);
        read_check("snap_hi", 6'd1, 32'h1);
        read_check("live_lo_any", 6'd2, 32'h11 & CTRL_RB | 32'h1);
        bus_write(6'd16, 32'h1);
        read_check("snap_lo2_dummy", 6'd3, 32'h0);
        bus_write(6'd16, 32'h0);
        begin
            logic [31:0] d;
            bus_read(6'd0, d);
        end
        read_check("carried_hi", 6'd1, 32'h2);

        // 5: LO write beats increment; clr_all beats increment
        bus_write(6'd0, 32'h0000_0100);
        read_check("wr_beats_inc", 6'd0, 32'h0000_0100);
        bus_write(6'd16, 32'h2);
        read_check("clr_beats_inc", 6'd0, 32'h0);

        // 6: freeze mid-count, then async reset during a read
        bus_write(6'd16, 32'h1);
        read_check("frz_a", 6'd0, 32'd3);
        repeat (20) @(negedge clk);
        read_check("frz_b", 6'd0, 32'd3);

        ct_req = 1'b1; ct_we = 1'b0; ct_addr = 6'd0;
        @(negedge clk);
        ct_req = 1'b0;
        rst_n = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j == 2) rst_n = 1'b1;
            check($sformatf("rst_rvalid%0d", j), {63'd0, ct_rvalid}, 64'd0);
            @(negedge clk);
        end
        check("rst_rdata", {32'd0, ct_rdata}, 64'd0);
        read_check("rst_lo0", 6'd0, 32'h0);
        read_check("rst_ctrl0", 6'd2, 32'h0);
        read_check("rst_gctrl", 6'd16, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
